// File: rtl/muldiv_unit.sv
// Iterative radix-2 M-extension unit: MUL/MULH*/DIV*/REM* and W-forms.
// A start/busy/done handshake lets EX stall until the result is ready.
module muldiv_unit #(
   parameter int XLEN      = 64,
   parameter int SUPPORT_W = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [2:0]      funct3_i,
   input  logic            word_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   localparam bit W_OK = (SUPPORT_W != 0) && (XLEN == 64);
   localparam int CW   = 7;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = '0;
      r[31:0] = v;
      return r;
   endfunction

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q;
   logic [2:0]        op_q;
   logic              w_q;
   logic              neg_q;
   logic              nega_q;
   logic [2*XLEN-1:0] mcand_q;
   logic [2*XLEN-1:0] prod_q;
   logic [XLEN-1:0]   mplier_q;
   logic [XLEN-1:0]   quo_q;
   logic [XLEN-1:0]   rem_q;
   logic [XLEN-1:0]   dvsr_q;
   logic [XLEN-1:0]   result_q;

   logic              w_in;
   logic              is_div;
   logic              sgn_a;
   logic              sgn_b;
   logic              neg_a;
   logic              neg_b;
   logic [XLEN-1:0]   a_ext;
   logic [XLEN-1:0]   b_ext;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic [XLEN-1:0]   dvd;
   logic [XLEN-1:0]   min_n;
   logic              b_zero;
   logic              ovf;
   logic              special;
   logic [XLEN-1:0]   spec_res;

   // Operand decode: extension, sign extraction and fast-path detection.
   always_comb begin
      w_in   = W_OK && word_i;
      is_div = funct3_i[2];
      sgn_a  = (funct3_i == 3'b001) || (funct3_i == 3'b010)
               || (funct3_i[2] && !funct3_i[0]);
      sgn_b  = (funct3_i == 3'b001) || (funct3_i[2] && !funct3_i[0]);
      a_ext  = a_i;
      b_ext  = b_i;
      if (w_in) begin
         a_ext = sgn_a ? sext32(a_i[31:0]) : zext32(a_i[31:0]);
         b_ext = sgn_b ? sext32(b_i[31:0]) : zext32(b_i[31:0]);
      end
      neg_a  = sgn_a && a_ext[XLEN-1];
      neg_b  = sgn_b && b_ext[XLEN-1];
      mag_a  = neg_a ? -a_ext : a_ext;
      mag_b  = neg_b ? -b_ext : b_ext;
      dvd    = w_in ? sext32(a_i[31:0]) : a_i;
      min_n  = w_in ? sext32(32'h8000_0000)
                    : {1'b1, {(XLEN-1){1'b0}}};
      b_zero = (b_ext == '0);
      ovf    = is_div && !funct3_i[0]
               && (a_ext == min_n) && (b_ext == '1);
      special  = is_div && (b_zero || ovf);
      spec_res = '0;
      if (b_zero)
         spec_res = funct3_i[1] ? dvd : '1;
      else if (ovf)
         spec_res = funct3_i[1] ? '0 : dvd;
   end

   logic [XLEN:0]     sh;
   logic [XLEN:0]     diff;
   logic [2*XLEN-1:0] prod_nx;

   // One radix-2 step for both engines; only the latched op's is used.
   always_comb begin
      sh      = {rem_q, quo_q[XLEN-1]};
      diff    = sh - {1'b0, dvsr_q};
      prod_nx = mplier_q[0] ? prod_q + mcand_q : prod_q;
   end

   logic [2*XLEN-1:0] pfix;
   logic [XLEN-1:0]   qfix;
   logic [XLEN-1:0]   rfix;
   logic [XLEN-1:0]   dsel;
   logic [XLEN-1:0]   fix_res;

   // Sign fix-up and half/word selection of the final result.
   always_comb begin
      pfix = neg_q ? -prod_q : prod_q;
      qfix = neg_q ? -quo_q : quo_q;
      rfix = nega_q ? -rem_q : rem_q;
      dsel = op_q[1] ? rfix : qfix;
      if (op_q[2])
         fix_res = w_q ? sext32(dsel[31:0]) : dsel;
      else if (w_q)
         fix_res = sext32(pfix[31:0]);
      else if (op_q[1:0] == 2'b00)
         fix_res = pfix[XLEN-1:0];
      else
         fix_res = pfix[2*XLEN-1:XLEN];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic; flush overrides everything.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start_i) state_d = special ? S_DONE : S_CALC;
         S_CALC: if (cnt_q == '0) state_d = S_FIX;
         S_FIX:  state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush_i)
         state_d = S_IDLE;
   end

   // Handshake outputs decoded from state.
   always_comb begin
      busy_o   = (state_q == S_CALC) || (state_q == S_FIX);
      done_o   = (state_q == S_DONE);
      result_o = result_q;
   end

   // Datapath: operand latch, iteration, and result write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         op_q     <= '0;
         w_q      <= 1'b0;
         neg_q    <= 1'b0;
         nega_q   <= 1'b0;
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         dvsr_q   <= '0;
         result_q <= '0;
      end else if (!flush_i) begin
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  cnt_q    <= w_in ? CW'(31) : CW'(XLEN-1);
                  op_q     <= funct3_i;
                  w_q      <= w_in;
                  neg_q    <= neg_a ^ neg_b;
                  nega_q   <= neg_a;
                  mcand_q  <= {{XLEN{1'b0}}, mag_a};
                  prod_q   <= '0;
                  mplier_q <= mag_b;
                  quo_q    <= w_in ? (mag_a << 32) : mag_a;
                  rem_q    <= '0;
                  dvsr_q   <= mag_b;
                  if (special)
                     result_q <= spec_res;
               end
            end
            S_CALC: begin
               cnt_q    <= cnt_q - 1'b1;
               prod_q   <= prod_nx;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               if (!diff[XLEN]) begin
                  rem_q <= diff[XLEN-1:0];
                  quo_q <= {quo_q[XLEN-2:0], 1'b1};
               end else begin
                  rem_q <= sh[XLEN-1:0];
                  quo_q <= {quo_q[XLEN-2:0], 1'b0};
               end
            end
            S_FIX:   result_q <= fix_res;
            default: ;
         endcase
      end
   end

endmodule
